axo_peri_gpio_irq: RTL and testbench



---
 rtl/axo_peri_gpio_irq.sv | 146 ++++++++++++++
 tb/tb_axo_peri_gpio_irq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axo_peri_gpio_irq.sv
// Multi-bank GPIO with atomic set/clear/toggle output writes, an input synchroniser,
// and per-pin edge interrupts. Status bits are write-1-to-clear and feed a single level irq.
module axo_peri_gpio_irq #(
    parameter int banks        = 2,
    parameter int num_pins     = 32,
    parameter int sync_stages  = 2,
    parameter bit invert_oe    = 1'b0,
    parameter bit invert_level = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [11:0]               bus_addr_i,
    input  logic                      bus_we_i,
    input  logic                      bus_re_i,
    input  logic [31:0]               bus_wdata_i,
    output logic [31:0]               bus_rdata_o,
    output logic                      bus_ready_o,
    input  logic [banks*num_pins-1:0] pin_in_i,
    output logic [banks*num_pins-1:0] pin_out_o,
    output logic [banks*num_pins-1:0] pin_oe_o,
    output logic                      irq_o
);

    localparam logic [31:0] PIN_MASK = 32'((64'd1 << num_pins) - 64'd1);
    localparam logic [31:0] LVL_MASK = invert_level ? PIN_MASK : 32'd0;

    localparam logic [3:0] REG_DIR      = 4'd0;
    localparam logic [3:0] REG_OUT      = 4'd1;
    localparam logic [3:0] REG_IN       = 4'd2;
    localparam logic [3:0] REG_OUT_SET  = 4'd3;
    localparam logic [3:0] REG_OUT_CLR  = 4'd4;
    localparam logic [3:0] REG_OUT_TGL  = 4'd5;
    localparam logic [3:0] REG_IRQ_EN   = 4'd6;
    localparam logic [3:0] REG_IRQ_RISE = 4'd7;
    localparam logic [3:0] REG_IRQ_FALL = 4'd8;
    localparam logic [3:0] REG_IRQ_STAT = 4'd9;

    logic [3:0]                  reg_sel;
    logic [3:0]                  bank_sel;
    logic [31:0]                 wmask;
    logic [banks-1:0][31:0]      rd_bank;
    logic [banks-1:0]            irq_bank;
    logic                        unused_bus_bits;

    assign reg_sel         = bus_addr_i[3:0];
    assign bank_sel        = bus_addr_i[7:4];
    assign wmask           = bus_wdata_i & PIN_MASK;
    assign bus_ready_o     = 1'b1;
    // Reads are side-effect free and the upper address bits alias, so these stay unused.
    assign unused_bus_bits = ^{bus_re_i, bus_addr_i[11:8]};

    generate
        for (genvar gi = 0; gi < banks; gi++) begin : g_bank
            logic [31:0]                  dir_q, out_q, en_q, rise_q, fall_q, stat_q, prev_q;
            logic [31:0]                  out_d, stat_d;
            logic [31:0]                  pad_in, s_last, evt, rd_val;
            logic [sync_stages-1:0][31:0] sync_q;
            logic                         wr_sel;

            assign wr_sel = bus_we_i && (bank_sel == 4'(gi));
            assign pad_in = 32'(pin_in_i[gi*num_pins +: num_pins]);
            assign s_last = sync_q[sync_stages-1] ^ LVL_MASK;
            assign evt    = (s_last & ~prev_q & rise_q) | (~s_last & prev_q & fall_q);

            always_comb begin
                out_d = out_q;
                if (wr_sel) begin
                    case (reg_sel)
                        REG_OUT:     out_d = wmask;
                        REG_OUT_SET: out_d = out_q | wmask;
                        REG_OUT_CLR: out_d = out_q & ~wmask;
                        REG_OUT_TGL: out_d = out_q ^ wmask;
                        default:     out_d = out_q;
                    endcase
                end
                stat_d = stat_q;
                if (wr_sel && reg_sel == REG_IRQ_STAT) begin
                    stat_d = stat_q & ~wmask;
                end
                // A new edge event overrides a clear landing in the same cycle.
                stat_d = stat_d | evt;
            end

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    dir_q  <= '0;
                    out_q  <= '0;
                    en_q   <= '0;
                    rise_q <= '0;
                    fall_q <= '0;
                    stat_q <= '0;
                    prev_q <= '0;
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[sync_stages-2:0], pad_in};
                    prev_q <= s_last;
                    out_q  <= out_d;
                    stat_q <= stat_d;
                    if (wr_sel) begin
                        case (reg_sel)
                            REG_DIR:      dir_q  <= wmask;
                            REG_IRQ_EN:   en_q   <= wmask;
                            REG_IRQ_RISE: rise_q <= wmask;
                            REG_IRQ_FALL: fall_q <= wmask;
                            default:      ;
                        endcase
                    end
                end
            end

            always_comb begin
                case (reg_sel)
                    REG_DIR:      rd_val = dir_q;
                    REG_OUT,
                    REG_OUT_SET,
                    REG_OUT_CLR,
                    REG_OUT_TGL:  rd_val = out_q;
                    REG_IN:       rd_val = s_last;
                    REG_IRQ_EN:   rd_val = en_q;
                    REG_IRQ_RISE: rd_val = rise_q;
                    REG_IRQ_FALL: rd_val = fall_q;
                    REG_IRQ_STAT: rd_val = stat_q;
                    default:      rd_val = 32'd0;
                endcase
            end

            assign rd_bank[gi]  = rd_val;
            assign irq_bank[gi] = |(stat_q & en_q);
            assign pin_oe_o[gi*num_pins +: num_pins]  = dir_q[num_pins-1:0] ^ {num_pins{invert_oe}};
            assign pin_out_o[gi*num_pins +: num_pins] = out_q[num_pins-1:0] ^ {num_pins{invert_level}};
        end
    endgenerate

    // Bank indices with no bank behind them fall through to zero.
    always_comb begin
        bus_rdata_o = 32'd0;
        for (int b = 0; b < banks; b++) begin
            if (bank_sel == 4'(b)) begin
                bus_rdata_o = rd_bank[b];
            end
        end
    end

    assign irq_o = |irq_bank;

endmodule

// File: tb/tb_axo_peri_gpio_irq.sv
// Self-checking bench for axo_peri_gpio_irq: register access, atomic outputs,
// synchroniser latency, edge interrupts, set-beats-clear, decode and masking.
module tb_axo_peri_gpio_irq;

    localparam int NB = 2;
    localparam int NP = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [11:0]       bus_addr = '0;
    logic              bus_we = 1'b0;
    logic              bus_re = 1'b0;
    logic [31:0]       bus_wdata = '0;
    logic [31:0]       bus_rdata;
    logic              bus_ready;
    logic [NB*NP-1:0]  pin_in = '0;
    logic [NB*NP-1:0]  pin_out;
    logic [NB*NP-1:0]  pin_oe;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;

    string       tag_q[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    axo_peri_gpio_irq #(
        .banks(NB), .num_pins(NP), .sync_stages(2), .invert_oe(1'b0), .invert_level(1'b0)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .bus_addr_i(bus_addr), .bus_we_i(bus_we), .bus_re_i(bus_re),
        .bus_wdata_i(bus_wdata), .bus_rdata_o(bus_rdata), .bus_ready_o(bus_ready),
        .pin_in_i(pin_in), .pin_out_o(pin_out), .pin_oe_o(pin_oe), .irq_o(irq)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] want);
        tag_q.push_back(tag);
        exp_q.push_back(want);
    endtask

    task automatic sb_pop(input logic [63:0] got);
        string       t;
        logic [63:0] w;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            t = tag_q.pop_front();
            w = exp_q.pop_front();
            chk(t, got, w);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the following posedge.
    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        bus_addr  = addr;
        bus_wdata = data;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] addr, input logic [31:0] want);
        sb_push(tag, 64'(want));
        bus_addr = addr;
        bus_re   = 1'b1;
        #1;
        sb_pop(64'(bus_rdata));
        bus_re   = 1'b0;
    endtask

    task automatic obs(input string tag, input logic [63:0] got, input logic [63:0] want);
        sb_push(tag, want);
        sb_pop(got);
    endtask

    logic [31:0] out_model;

    initial begin
        // Reset: pads toggling under reset must not reach outputs
        for (int i = 0; i < 3; i++) begin
            pin_in = {$urandom, $urandom};
            step(1);
            obs("rst_oe", pin_oe, 64'd0);
            obs("rst_out", pin_out, 64'd0);
            obs("rst_irq", 64'(irq), 64'd0);
            obs("rst_ready", 64'(bus_ready), 64'd1);
        end
        pin_in = '0;
        step(3);
        rst_n = 1'b1;
        step(1);
        for (int b = 0; b < NB; b++) begin
            for (int r = 0; r < 10; r++) begin
                rd_check($sformatf("rst_reg_b%0d_r%0d", b, r), 12'((b << 4) | r), 32'd0);
            end
        end

        // Atomic output writes on bank 1
        wr(12'h010, 32'hFFFF_FFFF);
        out_model = 32'h0000_00F0;
        wr(12'h011, 32'h0000_00F0);
        rd_check("out_wr", 12'h011, out_model);
        out_model = out_model | 32'h3;
        wr(12'h013, 32'h3);
        rd_check("out_set", 12'h013, out_model);
        out_model = out_model & ~32'h30;
        wr(12'h014, 32'h30);
        rd_check("out_clr", 12'h014, out_model);
        out_model = out_model ^ 32'h101;
        wr(12'h015, 32'h101);
        rd_check("out_tgl", 12'h015, out_model);
        obs("pad_out", pin_out, {out_model, 32'd0});
        obs("pad_oe", pin_oe, {32'hFFFF_FFFF, 32'd0});

        // Synchroniser latency: visible after edge 2, not edge 1
        pin_in[5] = 1'b1;
        step(1);
        rd_check("sync_e1", 12'h002, 32'h0);
        step(1);
        rd_check("sync_e2", 12'h002, 32'h20);
        pin_in[5] = 1'b0;
        step(4);
        rd_check("no_evt_disabled", 12'h009, 32'h0);

        // Rising-edge IRQ on bank 0 bit 5
        wr(12'h007, 32'h20);
        wr(12'h006, 32'h20);
        pin_in[5] = 1'b1;
        sb_push("rise_irq_e1", 64'd0);
        sb_push("rise_irq_e2", 64'd0);
        sb_push("rise_irq_e3", 64'd1);
        for (int e = 0; e < 3; e++) begin
            step(1);
            sb_pop(64'(irq));
        end
        rd_check("rise_stat", 12'h009, 32'h20);
        pin_in[5] = 1'b0;
        step(4);
        rd_check("fall_no_evt", 12'h009, 32'h20);
        wr(12'h009, 32'h20);
        obs("w1c_irq", 64'(irq), 64'd0);
        rd_check("w1c_stat", 12'h009, 32'h0);

        // Set beats clear on bank 0 bit 0
        wr(12'h008, 32'h1);
        wr(12'h006, 32'h21);
        pin_in[0] = 1'b1;
        step(4);
        rd_check("bit0_rise_off", 12'h009, 32'h0);
        pin_in[0] = 1'b0;
        step(2);
        wr(12'h009, 32'h1);
        rd_check("set_wins_stat", 12'h009, 32'h1);
        obs("set_wins_irq", 64'(irq), 64'd1);
        wr(12'h009, 32'h1);
        rd_check("clr_after", 12'h009, 32'h0);
        obs("clr_after_irq", 64'(irq), 64'd0);

        // Decode: missing bank and unmapped register
        wr(12'h021, 32'h0000_FFFF);
        rd_check("bank2_rd", 12'h021, 32'h0);
        rd_check("bank0_out", 12'h001, 32'h0);
        rd_check("bank1_out", 12'h011, out_model);
        rd_check("unmapped", 12'h00A, 32'h0);

        // IRQ_EN masks irq only
        wr(12'h017, 32'h8);
        wr(12'h016, 32'h0);
        pin_in[35] = 1'b1;
        step(3);
        rd_check("mask_stat", 12'h019, 32'h8);
        obs("mask_irq", 64'(irq), 64'd0);
        wr(12'h016, 32'h8);
        obs("unmask_irq", 64'(irq), 64'd1);

        // Reset mid-operation discards pending status
        rst_n = 1'b0;
        #1;
        obs("midrst_irq", 64'(irq), 64'd0);
        step(1);
        rst_n = 1'b1;
        step(1);
        rd_check("midrst_stat", 12'h019, 32'h0);
        rd_check("midrst_out", 12'h011, 32'h0);
        step(4);
        rd_check("spurious_rise", 12'h019, 32'h0);
        obs("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
